// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared states and constants for the instruction memory loader.
package imem_loader_pkg;
    typedef enum logic [2:0] {IDLE, HDR, DATA, WRITE, CHK, DONE, ERR} loader_state_t;
    localparam int WORD_BYTES = 4;
    localparam int WL_W = 16;
endpackage

// File: rtl/imem_loader_byte_word_assembler.sv
// byte_word_assembler: merges accepted bytes into a little-endian 32-bit word.
module byte_word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        accept,
    input  logic [1:0]  idx,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_complete
);
    logic [31:0] word_q, word_d;
    always_comb begin
        word_d = word_q;
        if (accept) word_d[{idx, 3'b000} +: 8] = byte_in;
    end
    // word includes the byte being accepted so the 4th byte is usable in its own cycle
    assign word = word_d;
    assign word_complete = accept && idx == 2'(WORD_BYTES - 1);
    always_ff @(posedge clk) begin
        if (reset) word_q <= '0;
        else       word_q <= word_d;
    end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: byte stream to instruction memory word writer, holding the core while loading.
// Define LOADER_CHECKSUM_EN to require a trailing sum-of-words check word.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          MEM_BYTES      = 1024,
    parameter logic [31:0] BASE_ADDR      = 32'h0,
    parameter int          TIMEOUT_CYCLES = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [7:0]      byte_in,
    input  logic            byte_valid,
    output logic            byte_ready,
    output logic            write_enable,
    output logic [31:0]     write_addr,
    output logic [31:0]     write_data,
    output logic            cpu_hold,
    output logic            busy,
    output logic            done,
    output logic            error,
    output logic [WL_W-1:0] words_loaded
);
    localparam logic [31:0] MAX_WORDS = 32'(MEM_BYTES / WORD_BYTES);
`ifdef LOADER_CHECKSUM_EN
    localparam loader_state_t FINAL_STATE = CHK;
    logic [31:0] sum_q, sum_d;
`else
    localparam loader_state_t FINAL_STATE = DONE;
`endif
    loader_state_t   state_q, state_d;
    logic [1:0]      idx_q, idx_d;
    logic [31:0]     n_q, n_d, addr_q, addr_d, data_q, data_d, idle_q, idle_d;
    logic [WL_W-1:0] wl_q, wl_d;
    logic            busy_q, busy_d, done_q, done_d, error_q, error_d;
    logic            accept, word_complete;
    logic [31:0]     asm_word;

    assign byte_ready   = state_q inside {HDR, DATA, CHK};
    assign accept       = byte_valid && byte_ready;
    assign write_enable = state_q == WRITE;
    assign write_addr   = addr_q;
    assign write_data   = data_q;
    assign cpu_hold     = busy_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign words_loaded = wl_q;

    byte_word_assembler u_asm (
        .clk(clk), .reset(reset), .accept(accept), .idx(idx_q), .byte_in(byte_in),
        .word(asm_word), .word_complete(word_complete)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = accept ? idx_q + 2'd1 : idx_q;
        n_d     = n_q;
        wl_d    = wl_q;
        addr_d  = addr_q;
        data_d  = data_q;
        busy_d  = busy_q;
        done_d  = done_q;
        error_d = error_q;
        idle_d  = (byte_ready && !accept) ? idle_q + 32'd1 : '0;
`ifdef LOADER_CHECKSUM_EN
        sum_d   = sum_q;
`endif
        case (state_q)
            IDLE: if (start) begin
                state_d = HDR;
                idx_d   = '0;
                wl_d    = '0;
                busy_d  = 1'b1;
                done_d  = 1'b0;
                error_d = 1'b0;
`ifdef LOADER_CHECKSUM_EN
                sum_d   = '0;
`endif
            end
            HDR: if (word_complete) begin
                n_d     = asm_word;
                state_d = asm_word == 32'd0 ? FINAL_STATE : (asm_word > MAX_WORDS ? ERR : DATA);
            end
            DATA: if (word_complete) begin
                state_d = WRITE;
                data_d  = asm_word;
                addr_d  = BASE_ADDR + (32'(wl_q) << 2);
            end
            WRITE: begin
                wl_d    = wl_q + 1'b1;
                state_d = 32'(wl_d) < n_q ? DATA : FINAL_STATE;
`ifdef LOADER_CHECKSUM_EN
                sum_d   = sum_q + data_q;
`endif
            end
`ifdef LOADER_CHECKSUM_EN
            CHK: if (word_complete) state_d = asm_word == sum_q ? DONE : ERR;
`endif
            default: state_d = IDLE;
        endcase
        if (TIMEOUT_CYCLES > 0 && byte_ready && !accept && idle_d == 32'(TIMEOUT_CYCLES)) state_d = ERR;
        if (state_d == DONE || state_d == ERR) busy_d = 1'b0;
        if (state_d == DONE) done_d = 1'b1;
        if (state_d == ERR) error_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            n_q     <= '0;
            wl_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            idle_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            n_q     <= n_d;
            wl_q    <= wl_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            idle_q  <= idle_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side master for the instruction memory's load port.
- Consumes a byte stream (e.g. from a UART receiver) over a valid/ready handshake.
- Assembles little-endian 32-bit words and issues one word write per instruction to write_enable/write_addr/write_data.
- Holds the core in reset (cpu_hold) while a program image is loading.

Parameters:
- MEM_BYTES, 1024, size of the target instruction memory in bytes; maximum word count is MEM_BYTES/4.
- BASE_ADDR, 32'h0, byte address of the first loaded word; must be 4-aligned.
- TIMEOUT_CYCLES, 0, idle cycles allowed between accepted bytes while loading; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse that begins a load session
- byte_in  in  8  stream data
- byte_valid  in  1  byte_in is valid
- byte_ready  out  1  loader accepts a byte this cycle
- write_enable  out  1  one-cycle word write strobe to the instruction memory
- write_addr  out  32  byte address of the write, always 4-aligned
- write_data  out  32  assembled instruction word
- cpu_hold  out  1  high while busy; held in the core's reset
- busy  out  1  session in progress
- done  out  1  sticky; load completed successfully
- error  out  1  sticky; load aborted
- words_loaded  out  16  count of words written this session

Behaviour:
- Reset: state IDLE; all outputs 0; word counter and byte index cleared. Reset mid-session aborts immediately with no further writes. Memory contents are not touched.
- Stream format: 4-byte word count N (little-endian), then N words of 4 bytes each (little-endian). The first byte of a group goes to bits [7:0].
- A byte is accepted only when byte_valid && byte_ready.
- byte_ready = 1 only in HDR and DATA states.
- States:
  - IDLE: start=1 moves to HDR. This clears done, error, words_loaded and the byte index, and sets busy/cpu_hold on the next cycle.
  - HDR: collect 4 bytes into N.
    - N == 0 → DONE.
    - N > MEM_BYTES/4 → ERR.
    - Otherwise → DATA.
  - DATA: collect 4 bytes. On the cycle after the 4th accepted byte, go to WRITE.
  - WRITE: exactly one cycle.
    - write_enable = 1.
    - write_addr = BASE_ADDR + 4*words_loaded (32-bit wrap).
    - write_data = assembled word.
    - words_loaded increments at the end of the cycle.
    - Next state: DATA if words_loaded+1 < N, otherwise DONE (or CHK, see Optional Feature).
  - DONE: done=1, busy=0, cpu_hold=0; returns to IDLE on the same cycle. done stays asserted until the next start.
  - ERR: error=1, busy=0, cpu_hold=0, → IDLE. error is sticky until the next start. Words already written remain in memory.
- Latency:
  - 4th byte accepted in cycle t → write_enable in cycle t+1.
  - Minimum throughput is 5 cycles per word.
- write_addr/write_data hold their last value when write_enable=0. Only write_enable carries meaning.
- start while busy is ignored; it does not restart the session.
- Timeout: with TIMEOUT_CYCLES>0, an idle counter runs in HDR/DATA.
  - It clears on every accepted byte.
  - Reaching TIMEOUT_CYCLES → ERR.
  - The counter does not run in WRITE.
- A byte offered while byte_ready=0 stays pending on the source side. The loader never drops a byte.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - After N words, state CHK collects one extra 4-byte word S (byte_ready=1).
  - S == sum of all N words mod 2^32 → DONE; mismatch → ERR.
  - S is never written to memory.
  - With N == 0 the expected sum is 0 and the checksum word is still required.
- Undefined: no CHK state and no running sum register; WRITE goes straight to DONE after the last word.

Decomposition:
- Shared package imem_loader_pkg:
  - state enum loader_state_t {IDLE, HDR, DATA, WRITE, CHK, DONE, ERR}.
  - Constant WORD_BYTES = 4.
  - Width constant for words_loaded.
- One natural sub-module: byte_word_assembler. It takes the byte index plus accept strobe and produces the 32-bit little-endian word and word_complete. It is reused for the header, data and checksum words.

Test Plan:
- Load 2 words: start; bytes 02 00 00 00, 13 05 10 00, 93 05 20 00 → write_enable twice: (addr 0, data 0x00100513) and (addr 4, data 0x00200593); done=1, words_loaded=2, cpu_hold falls after the second write.
- Header N=0 (00 00 00 00) → no write_enable; done=1 within 2 cycles of the last header byte.
- Header N=300 with MEM_BYTES=1024 → error=1, no writes, byte_ready=0 afterwards.
- Backpressure and stalls: byte_valid toggled randomly, BASE_ADDR=0x100, N=3 → writes at 0x100, 0x104, 0x108 in order; byte_ready=0 during every WRITE cycle; no byte lost or duplicated.
- Reset asserted in DATA after 2 bytes of word 1 → next cycle all outputs 0, state IDLE; a subsequent fresh load of N=1 writes addr 0 correctly.
- TIMEOUT_CYCLES=8: stall 8 cycles mid-word → error=1 and cpu_hold=0. With LOADER_CHECKSUM_EN defined, N=1 word 0x00000013 plus checksum 0x00000014 → error=1; with checksum 0x00000013 → done=1.
